surf_cin_generator: RTL



---
 rtl/surf_cin_pkg.sv | 13 +
 rtl/cin_bitslip.sv | 27 ++
 rtl/surf_cin_generator.sv | 77 +++++++
 3 files changed

// File: rtl/surf_cin_pkg.sv
// surf_cin_pkg: shared types and constants for the SURF command-in word generator
package surf_cin_pkg;
  typedef enum logic [1:0] {M_IDLE = 2'd0, M_TRAIN = 2'd1, M_RUN = 2'd2} mode_t;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_TRAIN = 2'd1;
  localparam state_t S_RUN = 2'd2;
  localparam state_t S_CMD = 2'd3;
  localparam logic [5:0] TRAIN_DEFAULT = 6'b011001;
  function automatic int slip_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/cin_bitslip.sv
// cin_bitslip: per-channel bit-slip that delays the word stream by a latched number of bits
module cin_bitslip
  import surf_cin_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int SW = slip_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [WIDTH-1:0] word,
  input  logic [SW-1:0]    rot,
  input  logic             rot_load,
  output logic [WIDTH-1:0] data
);
  logic [SW-1:0] slip;
  logic [WIDTH-1:0] word_prev;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      slip <= '0;
      word_prev <= '0;
      data <= '0;
    end else begin
      if (rot_load) slip <= int'(rot) >= WIDTH ? SW'(WIDTH - 1) : rot;
      word_prev <= word;
      data <= WIDTH'({word_prev, word} >> slip);
    end
endmodule

// File: rtl/surf_cin_generator.sv
// surf_cin_generator: per-SURF CIN word generator with idle/train/command streams, bit-slip and CLK_SYNC
module surf_cin_generator
  import surf_cin_pkg::*;
#(
  parameter int NSURF = 7,
  parameter int WIDTH = 6,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = TRAIN_DEFAULT,
  parameter int CMD_BITS = 24,
  parameter int SYNC_DELAY = 16
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [1:0]                      mode_i,
  input  logic [CMD_BITS-1:0]             cmd_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [NSURF*slip_w(WIDTH)-1:0]  rot_i,
  input  logic                            rot_load_i,
  input  logic                            sync_req_i,
  output logic                            sync_o,
  output logic                            busy_o,
  output logic [NSURF*WIDTH-1:0]          data_o
);
  localparam int CMD_WORDS = CMD_BITS / WIDTH;
  localparam int WCW = slip_w(CMD_WORDS);
  localparam int SW = slip_w(WIDTH);
  localparam int DW = slip_w(SYNC_DELAY + 1);
  state_t state, state_d, mode_state;
  logic [WCW-1:0] wcnt, wcnt_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic last, accept, req_q;
  logic [DW-1:0] sync_cnt;
  // word_q is built from next-state values so word 0 lands one edge after acceptance
  always_comb begin
    last = state == S_CMD && wcnt == WCW'(CMD_WORDS - 1);
    cmd_ready_o = mode_i == M_RUN && (state == S_RUN || last);
    accept = cmd_valid_i && cmd_ready_o;
    mode_state = mode_i == M_TRAIN ? S_TRAIN : mode_i == M_RUN ? S_RUN : S_IDLE;
    state_d = accept || (state == S_CMD && !last) ? S_CMD : mode_state;
    wcnt_d = accept ? '0 : state == S_CMD ? wcnt + 1'b1 : wcnt;
    cmd_d = accept ? cmd_i : state == S_CMD ? cmd_q << WIDTH : cmd_q;
    word_d = state_d == S_CMD ? cmd_d[CMD_BITS-1 -: WIDTH] : state_d == S_TRAIN ? TRAIN_PATTERN : '0;
  end
  assign busy_o = state == S_CMD;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= S_IDLE;
      wcnt <= '0;
      cmd_q <= '0;
      word_q <= '0;
      req_q <= 1'b0;
      sync_cnt <= '0;
      sync_o <= 1'b0;
    end else begin
      state <= state_d;
      wcnt <= wcnt_d;
      cmd_q <= cmd_d;
      word_q <= word_d;
      req_q <= sync_req_i;
      if (sync_req_i && !req_q) begin
        sync_cnt <= DW'(SYNC_DELAY);
        sync_o <= 1'b0;
      end else if (sync_cnt != '0) sync_cnt <= sync_cnt - 1'b1;
      else sync_o <= 1'b1;
    end
  for (genvar n = 0; n < NSURF; n++) begin : g_ch
    cin_bitslip #(.WIDTH(WIDTH), .SW(SW)) u_slip (
      .clk(clk),
      .rst_b(rst_b),
      .word(word_q),
      .rot(rot_i[n*SW +: SW]),
      .rot_load(rot_load_i),
      .data(data_o[n*WIDTH +: WIDTH])
    );
  end
endmodule
